// File: rtl/cp0_coprocessor_if.sv
// Bus between the decode Controller and coprocessor 0: MTC0/MFC0 access,
// exception requests, interrupt lines and the pipeline redirect.
interface cp0_coprocessor_if;
  logic        InstrValid;
  logic [31:0] CurrentPC;
  logic        InDelaySlot;
  logic        CP0WE;
  logic [4:0]  CP0WAddr;
  logic [31:0] CP0WData;
  logic        CP0RE;
  logic [4:0]  CP0RAddr;
  logic [31:0] CP0RData;
  logic        ExcSyscall;
  logic        ExcEret;
  logic [5:0]  HwInt;
  logic        ExcRequest;
  logic [31:0] ExcTarget;
  logic [31:0] StatusOut;
  logic [31:0] CauseOut;
  logic [31:0] EPCOut;
  logic        TimerInt;

  modport master (
    output InstrValid, CurrentPC, InDelaySlot, CP0WE, CP0WAddr, CP0WData,
           CP0RE, CP0RAddr, ExcSyscall, ExcEret, HwInt,
    input  CP0RData, ExcRequest, ExcTarget, StatusOut, CauseOut, EPCOut, TimerInt
  );

  modport slave (
    input  InstrValid, CurrentPC, InDelaySlot, CP0WE, CP0WAddr, CP0WData,
           CP0RE, CP0RAddr, ExcSyscall, ExcEret, HwInt,
    output CP0RData, ExcRequest, ExcTarget, StatusOut, CauseOut, EPCOut, TimerInt
  );
endinterface

// File: rtl/cp0_coprocessor.sv
// MIPS32 system coprocessor 0: Count/Compare timer, Status, Cause, EPC, PRId,
// and interrupt/syscall/eret arbitration driving a one-cycle pipeline redirect.
module cp0_coprocessor #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE = 32'h0001_8000,
  parameter bit          COUNT_DIV2 = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  cp0_coprocessor_if.slave  bus
);

  localparam logic [4:0]  ADDR_COUNT   = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE = 5'd11;
  localparam logic [4:0]  ADDR_STATUS  = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
  localparam logic [4:0]  ADDR_EPC     = 5'd14;
  localparam logic [4:0]  ADDR_PRID    = 5'd15;
  localparam logic [31:0] STATUS_MASK  = 32'h0000_FF03;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        timer_q, timer_d;
  logic        div_q, div_d;

  logic        int_pend;
  logic        take_int;
  logic        take_sys;
  logic        take_eret;
  logic        exc_entry;
  logic        exc_req;
  logic        mtc0;
  logic        tick;
  logic [31:0] count_inc;

  // Interrupt outranks syscall, which outranks eret; bubbles never redirect.
  always_comb begin
    int_pend  = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));
    take_int  = bus.InstrValid & int_pend;
    take_sys  = bus.InstrValid & ~int_pend & bus.ExcSyscall;
    take_eret = bus.InstrValid & ~int_pend & ~bus.ExcSyscall & bus.ExcEret;
    exc_entry = take_int | take_sys;
    exc_req   = exc_entry | take_eret;
    mtc0      = bus.CP0WE & bus.InstrValid & ~exc_req;
    tick      = COUNT_DIV2 ? div_q : 1'b1;
    count_inc = count_q + 32'd1;
  end

  // Next-state for every CP0 register; a squashed MTC0 has no effect.
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    timer_d   = timer_q;
    div_d     = COUNT_DIV2 ? ~div_q : 1'b0;

    if (mtc0 && bus.CP0WAddr == ADDR_COUNT) begin
      count_d = bus.CP0WData;
    end else if (tick) begin
      count_d = count_inc;
      if (count_inc == compare_q) timer_d = 1'b1;
    end

    if (mtc0 && bus.CP0WAddr == ADDR_COMPARE) begin
      compare_d = bus.CP0WData;
      timer_d   = 1'b0;
    end

    if (mtc0 && bus.CP0WAddr == ADDR_STATUS) status_d = bus.CP0WData & STATUS_MASK;
    if (mtc0 && bus.CP0WAddr == ADDR_CAUSE)  cause_d[9:8] = bus.CP0WData[9:8];
    if (mtc0 && bus.CP0WAddr == ADDR_EPC)    epc_d = bus.CP0WData;

    // Hardware lines are sampled every clock; the timer shares IP7.
    cause_d[15:10] = {bus.HwInt[5] | timer_q, bus.HwInt[4:0]};

    if (exc_entry) begin
      epc_d       = bus.InDelaySlot ? bus.CurrentPC - 32'd4 : bus.CurrentPC;
      cause_d[31] = bus.InDelaySlot;
      cause_d[6:2] = take_sys ? 5'd8 : 5'd0;
      status_d[1] = 1'b1;
    end else if (take_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= '0;
      cause_q   <= '0;
      epc_q     <= '0;
      timer_q   <= 1'b0;
      div_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
      div_q     <= div_d;
    end
  end

  always_comb begin
    bus.CP0RData = '0;
    if (bus.CP0RE) begin
      unique case (bus.CP0RAddr)
        ADDR_COUNT:   bus.CP0RData = count_q;
        ADDR_COMPARE: bus.CP0RData = compare_q;
        ADDR_STATUS:  bus.CP0RData = status_q;
        ADDR_CAUSE:   bus.CP0RData = cause_q;
        ADDR_EPC:     bus.CP0RData = epc_q;
        ADDR_PRID:    bus.CP0RData = PRID_VALUE;
        default:      bus.CP0RData = '0;
      endcase
    end
  end

  always_comb begin
    bus.ExcRequest = exc_req;
    bus.ExcTarget  = take_eret ? epc_q : (exc_entry ? EXC_VECTOR : 32'h0);
    bus.StatusOut  = status_q;
    bus.CauseOut   = cause_q;
    bus.EPCOut     = epc_q;
    bus.TimerInt   = timer_q;
  end

endmodule

// File: tb/tb_cp0_coprocessor.sv
// Directed bench for cp0_coprocessor: register access, syscall/eret, hardware
// interrupt entry, Count/Compare timer and asynchronous reset.
module tb_cp0_coprocessor;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  cp0_coprocessor_if bus ();

  cp0_coprocessor #(
    .EXC_VECTOR (32'h0000_4180),
    .PRID_VALUE (32'h0001_8000),
    .COUNT_DIV2 (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic ds,
                               input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic sys, input logic eret);
    bus.InstrValid  = valid;
    bus.CurrentPC   = pc;
    bus.InDelaySlot = ds;
    bus.CP0WE       = we;
    bus.CP0WAddr    = waddr;
    bus.CP0WData    = wdata;
    bus.ExcSyscall  = sys;
    bus.ExcEret     = eret;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic tickClk();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, addr, data, 1'b0, 1'b0);
    tickClk();
    idle();
  endtask

  task automatic readReg(input string tag, input logic [4:0] addr, input logic [31:0] expected);
    bus.CP0RE    = 1'b1;
    bus.CP0RAddr = addr;
    #1;
    checkOutput(tag, bus.CP0RData, expected);
    bus.CP0RE    = 1'b0;
    bus.CP0RAddr = 5'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.CP0RE    = 1'b0;
    bus.CP0RAddr = 5'd0;
    bus.HwInt    = 6'd0;
    idle();

    // Reset state
    #12;
    checkOutput("rst_status", bus.StatusOut, 32'h0);
    checkOutput("rst_cause", bus.CauseOut, 32'h0);
    checkOutput("rst_epc", bus.EPCOut, 32'h0);
    checkOutput("rst_timer", {31'd0, bus.TimerInt}, 32'h0);
    checkOutput("rst_excreq", {31'd0, bus.ExcRequest}, 32'h0);
    checkOutput("rst_rdata", bus.CP0RData, 32'h0);
    rst_n = 1'b1;
    tickClk();

    // Register field masks, PRId and unimplemented reads
    $display("[TB] register access");
    writeReg(5'd12, 32'h0000_FF03);
    readReg("status_rw", 5'd12, 32'h0000_FF03);
    writeReg(5'd12, 32'hFFFF_FFFF);
    readReg("status_mask", 5'd12, 32'h0000_FF03);
    writeReg(5'd13, 32'hFFFF_FFFF);
    readReg("cause_mask", 5'd13, 32'h0000_0300);
    readReg("prid", 5'd15, 32'h0001_8000);
    readReg("unimpl", 5'd3, 32'h0);
    bus.CP0RAddr = 5'd15;
    #1;
    checkOutput("re_low", bus.CP0RData, 32'h0);
    writeReg(5'd12, 32'h0);
    writeReg(5'd13, 32'h0);

    // Syscall outside a delay slot
    $display("[TB] syscall");
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("sys_req", {31'd0, bus.ExcRequest}, 32'h1);
    checkOutput("sys_target", bus.ExcTarget, 32'h0000_4180);
    tickClk();
    idle();
    checkOutput("sys_epc", bus.EPCOut, 32'h0000_0100);
    checkOutput("sys_cause", bus.CauseOut, 32'h0000_0020);
    checkOutput("sys_status", bus.StatusOut, 32'h0000_0002);

    // Syscall in a delay slot, then eret
    applyStimulus(1'b1, 32'h0000_0204, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    tickClk();
    idle();
    checkOutput("ds_epc", bus.EPCOut, 32'h0000_0200);
    checkOutput("ds_cause", bus.CauseOut, 32'h8000_0020);
    applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("eret_req", {31'd0, bus.ExcRequest}, 32'h1);
    checkOutput("eret_target", bus.ExcTarget, 32'h0000_0200);
    tickClk();
    idle();
    checkOutput("eret_status", bus.StatusOut, 32'h0);

    // Hardware interrupt squashes a concurrent MTC0 Compare
    $display("[TB] hardware interrupt");
    writeReg(5'd12, 32'h0000_0401);
    bus.HwInt = 6'b000001;
    applyStimulus(1'b1, 32'h0000_0400, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("int_lat0", {31'd0, bus.ExcRequest}, 32'h0);
    tickClk();
    bus.HwInt = 6'b000000;
    applyStimulus(1'b1, 32'h0000_0404, 1'b0, 1'b1, 5'd11, 32'h0000_1234, 1'b0, 1'b0);
    #1;
    checkOutput("int_req", {31'd0, bus.ExcRequest}, 32'h1);
    checkOutput("int_target", bus.ExcTarget, 32'h0000_4180);
    tickClk();
    idle();
    checkOutput("int_cause", bus.CauseOut, 32'h0);
    checkOutput("int_status", bus.StatusOut, 32'h0000_0403);
    checkOutput("int_epc", bus.EPCOut, 32'h0000_0404);
    readReg("int_cmp_kept", 5'd11, 32'h0);
    applyStimulus(1'b1, 32'h0000_0500, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("eret2_target", bus.ExcTarget, 32'h0000_0404);
    tickClk();
    idle();
    checkOutput("eret2_status", bus.StatusOut, 32'h0000_0401);

    // Timer: divided Count, sticky TimerInt, Compare clear, wrap
    $display("[TB] timer");
    writeReg(5'd12, 32'h0);
    writeReg(5'd11, 32'h0000_0008);
    checkOutput("tmr_idle", {31'd0, bus.TimerInt}, 32'h0);
    writeReg(5'd9, 32'h0000_0005);
    repeat (4) tickClk();
    checkOutput("tmr_early", {31'd0, bus.TimerInt}, 32'h0);
    repeat (2) tickClk();
    checkOutput("tmr_hit", {31'd0, bus.TimerInt}, 32'h1);
    readReg("tmr_count", 5'd9, 32'h0000_0008);
    tickClk();
    checkOutput("tmr_ip7", bus.CauseOut, 32'h0000_8000);
    checkOutput("tmr_sticky", {31'd0, bus.TimerInt}, 32'h1);
    writeReg(5'd11, 32'h0000_0100);
    checkOutput("tmr_clear", {31'd0, bus.TimerInt}, 32'h0);
    writeReg(5'd9, 32'hFFFF_FFFF);
    repeat (2) tickClk();
    readReg("tmr_wrap", 5'd9, 32'h0);

    // Interrupt from a delay slot at PC 0, then async reset mid-cycle
    $display("[TB] async reset");
    writeReg(5'd12, 32'h0000_0401);
    bus.HwInt = 6'b000001;
    applyStimulus(1'b1, 32'h0000_0600, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tickClk();
    applyStimulus(1'b1, 32'h0000_0000, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("int2_req", {31'd0, bus.ExcRequest}, 32'h1);
    tickClk();
    checkOutput("int2_epc", bus.EPCOut, 32'hFFFF_FFFC);
    checkOutput("int2_cause", bus.CauseOut, 32'h8000_0400);
    applyStimulus(1'b1, 32'h0000_0004, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_status", bus.StatusOut, 32'h0);
    checkOutput("ar_cause", bus.CauseOut, 32'h0);
    checkOutput("ar_epc", bus.EPCOut, 32'h0);
    checkOutput("ar_timer", {31'd0, bus.TimerInt}, 32'h0);
    checkOutput("ar_req", {31'd0, bus.ExcRequest}, 32'h0);
    checkOutput("ar_target", bus.ExcTarget, 32'h0);
    readReg("ar_epc_read", 5'd14, 32'h0);
    rst_n = 1'b1;
    bus.HwInt = 6'd0;
    idle();
    tickClk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
